// File: rtl/status_register_unit.sv
// NZCV flag register with same-cycle forwarding to ID, multiply-pending tracking,
// flag-hazard detection and a saved copy for exception entry/return.
module status_register_unit #(
    parameter bit          FORWARD     = 1'b1,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000,
    parameter int unsigned MAX_PEND    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    input  logic       ex_valid,
    input  logic       ex_s,
    input  logic [3:0] ex_flags,
    input  logic       mul_issue,
    input  logic       mul_flags_valid,
    input  logic [3:0] mul_flags,
    input  logic [3:0] id_cond,
    input  logic       id_s,
    input  logic       exc_enter,
    input  logic       exc_return,
    output logic [3:0] sr,
    output logic [3:0] sr_id,
    output logic [3:0] saved_sr,
    output logic       flag_hazard,
    output logic [1:0] pend_cnt,
    output logic       protocol_err
);

    localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);
    localparam logic [3:0] COND_AL  = 4'b1110;

    logic [3:0] sr_q, sr_d;
    logic [3:0] saved_q, saved_d;
    logic [1:0] pend_q, pend_d;
    logic       err_q, err_d;

    logic ex_wr, ret, ent, mul_ok;
    logic mul_inc, mul_dec;

    assign ex_wr   = ex_valid & ex_s & ~freeze;
    assign ret     = exc_return & ~freeze;
    assign ent     = exc_enter & ~freeze;
    assign mul_ok  = mul_flags_valid & (pend_q != 2'd0);
    assign mul_inc = mul_issue & ~mul_flags_valid;
    assign mul_dec = mul_flags_valid & ~mul_issue;

    always_comb begin
        sr_d    = sr_q;
        saved_d = saved_q;
        pend_d  = pend_q;
        err_d   = err_q;

        if (ret) begin
            sr_d = saved_q;
        end else if (ex_wr) begin
            sr_d = ex_flags;
        end else if (mul_ok) begin
            sr_d = mul_flags;
        end

        // Save always reads the pre-update flags, even when a restore shares the cycle.
        if (ent) begin
            saved_d = sr_q;
        end

        if (mul_inc) begin
            if (pend_q == PEND_MAX) begin
                err_d = 1'b1;
            end else begin
                pend_d = pend_q + 2'd1;
            end
        end else if (mul_dec && pend_q != 2'd0) begin
            pend_d = pend_q - 2'd1;
        end

        if ((mul_flags_valid && pend_q == 2'd0) || (ex_wr && mul_ok) || (ent && ret)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q    <= RESET_FLAGS;
            saved_q <= 4'b0000;
            pend_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            saved_q <= saved_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // The forwarded view is exactly the value sr will take at the next edge.
    assign sr_id        = FORWARD ? sr_d : sr_q;
    assign sr           = sr_q;
    assign saved_sr     = saved_q;
    assign pend_cnt     = pend_q;
    assign protocol_err = err_q;
    assign flag_hazard  = (pend_q != 2'd0) & ((id_cond != COND_AL) | id_s);

endmodule

// File: doc/status_register_unit.md
Name: status_register_unit

Overview:
- Holds the architectural NZCV flags.
- Produces the 4-bit status word consumed by the ID-stage condition checker.
- Forwards same-cycle EX flag updates, tracks outstanding S-setting multi-cycle multiplies and raises a flag hazard, and keeps a saved copy of the flags for exception entry and return.

Parameters:
- FORWARD, 1: 1 = bypass same-cycle flag writes onto sr_id; 0 = sr_id always equals sr.
- RESET_FLAGS, 4'b0000: value loaded into sr on reset.
- MAX_PEND, 3: maximum outstanding S-setting multiplies. Valid range 1..3; the counter is 2 bits wide.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  pipeline stall; blocks EX updates and exception operations.
- ex_valid  in  1  EX-stage instruction valid.
- ex_s  in  1  EX instruction sets flags (S bit).
- ex_flags  in  4  ALU flags, packed {z,c,n,v}.
- mul_issue  in  1  S-setting multiply issued this cycle.
- mul_flags_valid  in  1  multiplier result flags valid this cycle.
- mul_flags  in  4  multiplier flags, packed {z,c,n,v}.
- id_cond  in  4  condition field of the ID-stage instruction.
- id_s  in  1  ID-stage instruction sets flags.
- exc_enter  in  1  exception entry pulse.
- exc_return  in  1  exception return pulse.
- sr  out  4  registered flags {z,c,n,v}.
- sr_id  out  4  flags presented to the condition checker {z,c,n,v}.
- saved_sr  out  4  saved flags.
- flag_hazard  out  1  ID instruction must stall.
- pend_cnt  out  2  outstanding multiply count.
- protocol_err  out  1  sticky error.

Behaviour:
- **Reset:** while rst=0, asynchronously force sr=RESET_FLAGS, saved_sr=0, pend_cnt=0, protocol_err=0. Resetting mid-multiply discards the pending count. A mul_flags_valid arriving after reset sees pend_cnt=0 and is treated as an underflow.
- **Bit order:** bit3=z, bit2=c, bit1=n, bit0=v everywhere.
- **Term definitions:**
  - ex_wr = ex_valid & ex_s & ~freeze
  - ret = exc_return & ~freeze
  - ent = exc_enter & ~freeze
  - mul_ok = mul_flags_valid & (pend_cnt != 0)
- **sr next-state priority (highest first):**
  1. ret: sr <= saved_sr.
  2. ex_wr: sr <= ex_flags.
  3. mul_ok: sr <= mul_flags.
  4. Otherwise: hold.
- **Write latency:** one clock. Each write is visible on sr the cycle after the write cycle.
- **Exception entry:** on ent, saved_sr <= current registered sr, i.e. the value before this cycle's update.
- **Simultaneous exception pulses:** ent and ret in the same cycle set protocol_err. The save still occurs (from the pre-update sr), and the restore reads the old saved_sr.
- **sr_id (combinational), FORWARD=1:**
  - If ret: saved_sr.
  - Else if ex_wr: ex_flags.
  - Else if mul_ok: mul_flags.
  - Else: sr.
- **sr_id, FORWARD=0:** sr_id = sr.
- **pend_cnt:**
  - Increments on mul_issue alone.
  - Decrements on mul_flags_valid alone.
  - Unchanged when both occur in the same cycle.
  - Not affected by freeze; the multiplier runs independently.
- **Overflow:** mul_issue alone with pend_cnt==MAX_PEND sets protocol_err and holds the count.
- **Underflow:** mul_flags_valid with pend_cnt==0 sets protocol_err. Its flags are ignored for both sr and sr_id.
- **Write collision:** ex_wr and mul_ok in the same cycle: the EX write wins, the multiply flags are dropped, protocol_err is set, and pend_cnt still decrements.
- **flag_hazard (combinational):** flag_hazard = (pend_cnt != 0) & ((id_cond != 4'b1110) | id_s).
  - This stalls any conditional instruction, or any flag-setting instruction, behind an outstanding multiply.
  - id_cond = 4'b1111 is treated as conditional.
  - freeze does not affect flag_hazard.
- **protocol_err:** sticky; cleared only by reset.

Test Plan:
- Reset, then release rst -> sr=0000, sr_id=0000, saved_sr=0000, pend_cnt=0, flag_hazard=0.
- ex_valid=1, ex_s=1, ex_flags=1010, freeze=0 for one cycle -> sr_id=1010 in the same cycle (FORWARD=1), sr=1010 the next cycle. Repeat with freeze=1 -> sr unchanged, sr_id=old sr.
- mul_issue for one cycle; id_cond=0000 -> flag_hazard=1 while pend_cnt=1. Then mul_flags_valid with mul_flags=0100 -> sr_id=0100, flag_hazard=0 the next cycle, sr=0100.
- With pend_cnt=1, drive id_cond=1110 with id_s=0 -> flag_hazard=0; then id_s=1 -> flag_hazard=1.
- sr=0011, pulse exc_enter -> saved_sr=0011. Write ex_flags=1100, then pulse exc_return -> sr_id=0011 in the same cycle, sr=0011 the next cycle.
- Error cases:
  - mul_flags_valid with pend_cnt=0 -> protocol_err=1, sr unchanged.
  - Four mul_issue pulses -> pend_cnt saturates at 3, protocol_err=1.
  - Assert rst mid-sequence -> all outputs return to reset values immediately.
